// File: rtl/req_fifo_front.sv
// Per-requester request FIFOs feeding a round-robin arbiter; the granted head
// entry is forwarded with its source index to one registered valid/ready output.
module req_fifo_front #(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 4,
    localparam int unsigned SRC_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQS-1:0]        in_valid_i,
    output logic [NUM_REQS-1:0]        in_ready_o,
    input  logic [NUM_REQS*DATA_W-1:0] in_data_i,
    output logic [NUM_REQS-1:0]        req_o,
    input  logic [NUM_REQS-1:0]        grant_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_data_o,
    output logic [SRC_W-1:0]           out_src_o,
    output logic                       grant_err_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem    [NUM_REQS][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_REQS];
    logic [PTR_W-1:0]  rd_ptr [NUM_REQS];
    logic [CNT_W-1:0]  cnt    [NUM_REQS];

    logic [NUM_REQS-1:0] push;
    logic [NUM_REQS-1:0] pop;
    logic                load;
    logic                grant_multi;
    logic                grant_onehot;
    logic [SRC_W-1:0]    pop_idx;

    // Status comes only from registered counts; pops need a one-hot grant.
    always_comb begin
        load         = ~out_valid_o | out_ready_i;
        grant_multi  = (grant_i & (grant_i - NUM_REQS'(1))) != '0;
        grant_onehot = (grant_i != '0) && !grant_multi;
        pop_idx      = '0;
        in_ready_o   = '0;
        req_o        = '0;
        push         = '0;
        pop          = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            in_ready_o[i] = (cnt[i] != CNT_W'(DEPTH));
            req_o[i]      = (cnt[i] != '0);
            push[i]       = in_valid_i[i] & in_ready_o[i];
            pop[i]        = grant_i[i] & grant_onehot & req_o[i] & load;
            if (grant_i[i]) begin
                pop_idx = SRC_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
                    2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Storage needs no reset: cleared pointers make old contents unreachable.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_src_o   <= '0;
            grant_err_o <= 1'b0;
        end else begin
            if (grant_multi) begin
                grant_err_o <= 1'b1;
            end
            if (load) begin
                out_valid_o <= |pop;
                if (|pop) begin
                    out_data_o <= mem[pop_idx][rd_ptr[pop_idx]];
                    out_src_o  <= pop_idx;
                end
            end
        end
    end

endmodule

// File: doc/req_fifo_front.md
Name: req_fifo_front

Overview:
- Upstream front-end for the round-robin arbiter.
- Buffers requests from NUM_REQS independent producers in per-requester FIFOs and drives the arbiter's request vector from FIFO non-empty status.
- Consumes the arbiter's one-hot grant and forwards the granted head entry, with its source index, to a single registered valid/ready output.

Parameters:
NUM_REQS, 4, number of requesters; must match the arbiter.
DATA_W, 8, payload width per requester.
DEPTH, 4, entries per FIFO; power of two, minimum 2.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid_i  input  NUM_REQS  per-requester push valid
in_ready_o  output  NUM_REQS  per-requester push ready (FIFO not full)
in_data_i  input  NUM_REQS*DATA_W  packed payloads; requester i at bits [i*DATA_W +: DATA_W]
req_o  output  NUM_REQS  request vector to arbiter req_i; bit i = FIFO i non-empty
grant_i  input  NUM_REQS  grant vector from arbiter grant_o; one-hot or zero
out_valid_o  output  1  output entry valid (registered)
out_ready_i  input  1  downstream accepts output
out_data_o  output  DATA_W  forwarded payload (registered)
out_src_o  output  clog2(NUM_REQS)  index of the requester that supplied out_data_o
grant_err_o  output  1  sticky flag: a grant with more than one bit set was received

Behaviour:
- Reset (rst=0, asynchronous) clears all FIFO pointers and counts.
  - Reset output values: out_valid_o=0, out_data_o=0, out_src_o=0, grant_err_o=0, req_o=0.
  - in_ready_o is all-ones while reset is deasserted and FIFOs are empty.
- Reset mid-operation discards all buffered and output data; no partial state survives.
- Push: FIFO i writes in_data_i slice i on a clock edge where in_valid_i[i] and in_ready_o[i] are both high.
- in_ready_o[i] = (count[i] != DEPTH). There is no pass-through when full; a full FIFO never accepts, even if it is popped in the same cycle.
- req_o[i] = (count[i] != 0), derived only from registered counts, so there is no combinational path from in_valid_i or grant_i to req_o.
- Output load enable: load = ~out_valid_o | out_ready_i.
- Pop rule: FIFO i pops on an edge where all of the following hold:
  - grant_i[i]=1,
  - grant_i is one-hot,
  - count[i] != 0,
  - load=1.
- On a pop, out_data_o takes the head of FIFO i, out_src_o takes i, and out_valid_o is set to 1 on that edge.
- If load=1 and no pop qualifies, out_valid_o is cleared to 0.
- If load=0, the output registers hold, and a grant is ignored (not consumed, not queued).
- A stale grant (grant_i[i]=1 with FIFO i empty) is ignored; no pop occurs and no error is flagged.
- grant_i=0 is legal and idle.
- grant_i with popcount>1 causes no pop that cycle and sets grant_err_o; grant_err_o stays set until reset.
- Simultaneous push and pop on the same FIFO in one cycle: both occur, and the count is unchanged.
- Pointers wrap modulo DEPTH. Counts are clog2(DEPTH)+1 bits wide and range 0..DEPTH.
- FIFO order is strict per requester. There is no ordering guarantee across requesters; ordering across requesters is the arbiter's responsibility.
- Latency: push at edge t gives req_o high after edge t. With grant_i asserted in cycle t+k and load=1, data appears at out_data_o after edge t+k.
- Throughput: one entry per cycle when grants are continuous and out_ready_i=1.

Test Plan:
- Reset, single push: hold rst=0 for 2 cycles, then push 0xA5 on requester 2 -> req_o=4'b0100 next cycle; grant_i=4'b0100 with out_ready_i=1 -> out_valid_o=1, out_data_o=0xA5, out_src_o=2, req_o=0.
- Full FIFO: push 5 entries into requester 0 with no grant -> in_ready_o[0]=0 after the 4th accept; the 5th is not stored; popping 4 times yields 0x01..0x04 in order.
- Backpressure: out_valid_o=1, out_ready_i=0, grant_i=4'b0001 held for 3 cycles -> output holds the original data and the FIFO 0 count is unchanged; release out_ready_i -> the next entry loads on the following edge.
- Stale and illegal grants: grant_i=4'b1000 with FIFO 3 empty -> no pop, out_valid_o=0, grant_err_o=0. grant_i=4'b0011 with both FIFOs non-empty -> no pop, grant_err_o=1 and it stays 1 until reset.
- Simultaneous push and pop: FIFO 1 holding 2 entries, push 0x77 while grant_i=4'b0010 -> count stays 2, the popped value is the oldest entry, and 0x77 emerges last.
- Async reset mid-stream: assert rst=0 between clock edges while out_valid_o=1 -> out_valid_o=0 and req_o=0 immediately, without waiting for an edge; after release, all FIFOs are empty.
